// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell, LSB-first, WIDTH cycles per add.
// Optional subtract mode via macro SERIAL_ADDER_SUB_EN (adds input port sub).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   s_sr_q, s_sr_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;

  logic               accept;
  logic               last_bit;
  logic               fa_s;
  logic               fa_co;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

  full_adder u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept   = (state_q == IDLE) && start;
  assign last_bit = (state_q == RUN) && (cnt_q == CNT_LAST);

  // Subtraction is a + ~b + 1, so only the load values change.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_bit) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    sum  = sum_q;
    cout = cout_q;
  end

  always_comb begin
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    if (accept) begin
      a_sr_d  = a;
      b_sr_d  = b_load;
      s_sr_d  = '0;
      carry_d = carry_load;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
      b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
      s_sr_d  = {fa_s, s_sr_q[WIDTH-1:1]};
      carry_d = fa_co;
      cnt_d   = cnt_q + 1'b1;
      // The final sum bit is still in flight, so publish the shifted value.
      if (last_bit) begin
        sum_d  = {fa_s, s_sr_q[WIDTH-1:1]};
        cout_d = fa_co;
        done_d = 1'b1;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder stage that sits directly upstream of the team's full_adder cell.
- Holds two WIDTH-bit operands in shift registers and feeds the full_adder one bit pair per cycle, LSB first.
- Stores the cell's carry-out in a flop and returns it as the next cycle's carry-in.
- Collects sum bits into a result register. Trades latency for one adder cell; used where area matters more than throughput.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low, sampled on rising edge of clk
start  input  1  request a new addition; sampled only while idle
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  initial carry-in, captured on accepted start
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse when sum/cout become valid
sum  output  WIDTH  result, held until next accepted start
cout  output  1  final carry-out, held with sum

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; busy=0, done=0, sum=0, cout=0; carry flop, bit counter and shift registers cleared. Reset overrides all other inputs, including mid-run; any partial result is discarded and no done is issued.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE -> RUN: start=1 at edge k.
  - Load a and b into shift registers; carry flop <= cin; counter <= 0.
  - sum and cout are not cleared at this edge; they keep the previous result until overwritten by the run.
- RUN, at edges k+1 .. k+WIDTH:
  - full_adder inputs are a_sr[0], b_sr[0], carry flop (all combinational from registers).
  - At each edge: sum shift register shifts right with the cell's sum bit entering at the MSB; carry flop <= cell's cout; operand shift registers shift right; counter increments.
- On edge k+WIDTH (counter == WIDTH-1 before that edge):
  - sum <= completed shift value; cout <= cell's cout.
  - done <= 1; busy <= 0; state <= IDLE.
- Latency: done is high in the cycle after edge k+WIDTH, i.e. exactly WIDTH cycles after start was accepted. done deasserts at the following edge.
- start while busy=1: ignored, with no effect on operands or result.
- start in the done cycle: accepted (FSM is IDLE); done still pulses only once for the previous result.
- a, b and cin may change freely after the accepting edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- Counter width is $clog2(WIDTH). It never wraps inside a run; it is cleared on every accepted start.
- One full_adder instance only; no other adder logic in the block.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit), captured on accepted start.
  - sub=1: b is loaded bit-inverted and the carry flop is loaded with 1 (cin is ignored). Result: sum = a - b mod 2^WIDTH; cout = 1 when no borrow (a >= b, unsigned).
  - sub=0: behaviour identical to the undefined case.
- Undefined: no sub port; addition only.
- Latency and handshake are identical in both builds.

Test Plan (WIDTH=8):
1. a=0x0F, b=0x01, cin=0, start pulse -> busy=1 for 8 cycles; done pulse 8 cycles after accept; sum=0x10, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
3. Accept a=0x12, b=0x34; drive start=1 with a=0xAA, b=0x55 in run cycles 2-5 -> second request ignored; sum=0x46, cout=0; exactly one done pulse.
4. Hold start=1 continuously with a=0x01, b=0x01, cin=0 -> back-to-back runs; done pulse every 9 cycles (8 RUN cycles + 1 idle/accept cycle); sum=0x02 after each.
5. Accept a=0x80, b=0x80; drive rst_n=0 for one edge after 4 RUN cycles -> busy=0, sum=0x00, cout=0, no done. Next start with a=0x03, b=0x04 -> sum=0x07.
6. With SERIAL_ADDER_SUB_EN: sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0. sub=1, a=0x07, b=0x05 -> sum=0x02, cout=1.
